pc_unit: RTL and testbench

- Parametrised program-counter unit for the 5-stage MIPS pipeline; successor to the plain PC register.
- Adds the following over the plain PC register:
  - pipeline stall hold
  - prioritised redirect (exception > branch > jump > sequential)
  - a pending-redirect buffer, so a redirect raised during a stall is not lost
  - EPC capture on exception
- Sits in IF; feeds instruction memory address and IF/ID pc_4.

---
 rtl/pc_unit.sv | 158 +++++++++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// pc_unit : IF-stage program counter with stall hold, prioritised redirect
//           (EXC > BR > JMP > sequential), pending-redirect buffer and EPC.
//           Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned      STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_taken_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_req_i,
  input  logic [WIDTH-1:0] exc_pc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_4_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             pend_valid_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] C_EXC_TARGET = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] C_STEP       = WIDTH'(STEP);

  // Encoding order doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_JMP  = 2'd1,
    CLS_BR   = 2'd2,
    CLS_EXC  = 2'd3
  } req_cls_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  req_cls_e         pend_cls_q, pend_cls_d;
  logic             pend_valid_q, pend_valid_d;

  req_cls_e         live_cls, sel_cls;
  logic [WIDTH-1:0] live_tgt, sel_tgt;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    live_cls = CLS_NONE;
    live_tgt = '0;
    if (exc_req_i) begin
      live_cls = CLS_EXC;
      live_tgt = C_EXC_TARGET;
    end else if (br_taken_i) begin
      live_cls = CLS_BR;
      live_tgt = br_target_i;
    end else if (jmp_taken_i) begin
      live_cls = CLS_JMP;
      live_tgt = jmp_target_i;
    end

    // Live request wins ties against the buffered one of the same class.
    if (live_cls != CLS_NONE && live_cls >= pend_cls_q) begin
      sel_cls = live_cls;
      sel_tgt = live_tgt;
    end else begin
      sel_cls = pend_cls_q;
      sel_tgt = pend_tgt_q;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    pend_cls_d   = pend_cls_q;
    pend_tgt_d   = pend_tgt_q;
    pend_valid_d = pend_valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif

    if (exc_req_i) begin
      epc_d = exc_pc_i;
    end

    if (stall_i) begin
      if (live_cls != CLS_NONE &&
          (pend_cls_q == CLS_NONE || live_cls >= pend_cls_q)) begin
        pend_cls_d   = live_cls;
        pend_tgt_d   = live_tgt;
        pend_valid_d = 1'b1;
      end
    end else begin
      pend_cls_d   = CLS_NONE;
      pend_tgt_d   = '0;
      pend_valid_d = 1'b0;
      case (sel_cls)
        CLS_NONE: pc_d = pc_q + C_STEP;
        CLS_EXC:  pc_d = C_EXC_TARGET;
        default: begin
`ifdef PC_MISALIGN_TRAP_EN
          if (sel_tgt[1:0] != 2'b00) begin
            pc_d       = C_EXC_TARGET;
            epc_d      = sel_tgt;
            misalign_d = 1'b1;
          end else begin
            pc_d = sel_tgt;
          end
`else
          pc_d = {sel_tgt[WIDTH-1:2], 2'b00};
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      pend_cls_q   <= CLS_NONE;
      pend_tgt_q   <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      pend_cls_q   <= pend_cls_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_valid_q <= pend_valid_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o         = pc_q;
  assign pc_4_o       = pc_q + C_STEP;
  assign epc_o        = epc_q;
  assign pend_valid_o = pend_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_unit : directed + randomised bench for pc_unit against a cycle model.
// Revision: 1.0
// ============================================================================
module tb_pc_unit;

  localparam logic [31:0] EXC_V = 32'h0000_0180;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, br_taken = 1'b0, jmp_taken = 1'b0, exc_req = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0, exc_pc = '0;
  logic [31:0] pc, pc_4, epc;
  logic        pend_valid, misalign;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .br_taken_i(br_taken), .br_target_i(br_target),
    .jmp_taken_i(jmp_taken), .jmp_target_i(jmp_target),
    .exc_req_i(exc_req), .exc_pc_i(exc_pc),
    .pc_o(pc), .pc_4_o(pc_4), .epc_o(epc),
    .pend_valid_o(pend_valid), .misalign_o(misalign)
  );

  logic        rst16 = 1'b1, jmp16 = 1'b0;
  logic [15:0] jt16 = '0;
  logic [15:0] pc16, pc4_16, epc16;
  logic        pv16, mis16;

  pc_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .stall_i(1'b0),
    .br_taken_i(1'b0), .br_target_i(16'h0),
    .jmp_taken_i(jmp16), .jmp_target_i(jt16),
    .exc_req_i(1'b0), .exc_pc_i(16'h0),
    .pc_o(pc16), .pc_4_o(pc4_16), .epc_o(epc16),
    .pend_valid_o(pv16), .misalign_o(mis16)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state; priorities: 3 = exception, 2 = branch, 1 = jump, 0 = none.
  logic [31:0] m_pc = '0, m_epc = '0, m_ptgt = '0;
  int          m_pprio = 0;
  logic        m_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int          live_prio, win_prio;
    logic [31:0] live_tgt, win_tgt;
    if (rst) begin
      m_pc = '0; m_epc = '0; m_pprio = 0; m_ptgt = '0; m_mis = 1'b0;
      return;
    end
    live_prio = exc_req ? 3 : br_taken ? 2 : jmp_taken ? 1 : 0;
    live_tgt  = exc_req ? EXC_V : br_taken ? br_target : jmp_target;
    if (exc_req) m_epc = exc_pc;
    m_mis = 1'b0;
    if (stall) begin
      if (live_prio > 0 && live_prio >= m_pprio) begin
        m_pprio = live_prio;
        m_ptgt  = live_tgt;
      end
    end else begin
      win_prio = m_pprio; win_tgt = m_ptgt;
      if (live_prio > 0 && live_prio >= m_pprio) begin
        win_prio = live_prio; win_tgt = live_tgt;
      end
      if (win_prio == 0)      m_pc = m_pc + 32'd4;
      else if (win_prio == 3) m_pc = EXC_V;
      else if (win_tgt % 4 != 0) begin
`ifdef PC_MISALIGN_TRAP_EN
        m_pc  = EXC_V;
        m_mis = 1'b1;
        m_epc = win_tgt;
`else
        m_pc  = win_tgt - (win_tgt % 4);
`endif
      end else m_pc = win_tgt;
      m_pprio = 0;
    end
  endtask

  task automatic apply(input logic r, input logic st,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic e, input logic [31:0] ep);
    rst = r; stall = st; br_taken = b; br_target = bt;
    jmp_taken = j; jmp_target = jt; exc_req = e; exc_pc = ep;
    model_step();
    @(negedge clk);
    check("pc", pc, m_pc);
    check("pc_4", pc_4, m_pc + 32'd4);
    check("epc", epc, m_epc);
    check("pend_valid", {31'b0, pend_valid}, {31'b0, m_pprio != 0});
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    logic        r, st, b, j, e;
    logic [31:0] bt, jt, ep;
    @(negedge clk);
    apply(1, 0, 0, '0, 0, '0, 0, '0);
    check("reset_pc", pc, 32'h0);
    idle(3);
    check("free_run_pc", pc, 32'hC);
    apply(1, 0, 0, '0, 0, '0, 0, '0);
    check("rerst_pc", pc, 32'h0);
    idle(4);
    apply(0, 1, 0, '0, 0, '0, 0, '0);
    apply(0, 1, 0, '0, 0, '0, 0, '0);
    apply(0, 1, 0, '0, 0, '0, 0, '0);
    check("stall_hold", pc, 32'h10);
    idle(1);
    check("stall_release", pc, 32'h14);
    idle(3);
    apply(0, 0, 1, 32'h100, 1, 32'h200, 0, '0);
    check("br_over_jmp", pc, 32'h100);
    apply(0, 1, 1, 32'h300, 0, '0, 0, '0);
    apply(0, 1, 0, '0, 1, 32'h400, 0, '0);
    check("pend_held", {31'b0, pend_valid}, 32'h1);
    idle(1);
    check("pend_br_taken", pc, 32'h300);
    apply(0, 1, 1, 32'h302, 0, '0, 0, '0);
    idle(1);
    apply(0, 1, 1, 32'h300, 0, '0, 0, '0);
    apply(0, 1, 0, '0, 0, '0, 1, 32'h44);
    check("exc_epc", epc, 32'h44);
    idle(1);
    check("exc_vector", pc, EXC_V);
    apply(0, 1, 1, 32'h300, 0, '0, 0, '0);
    apply(1, 1, 0, '0, 0, '0, 0, '0);
    check("rst_in_stall_pv", {31'b0, pend_valid}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 35);
      b  = ($urandom_range(0, 99) < 20);
      j  = ($urandom_range(0, 99) < 20);
      e  = ($urandom_range(0, 99) < 8);
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 20) bt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 20) jt[1:0] = 2'($urandom_range(1, 3));
      ep = $urandom;
      apply(r, st, b, bt, j, jt, e, ep);
    end

    rst16 = 1'b1;
    @(negedge clk);
    check("w16_reset", {16'h0, pc16}, 32'h0);
    rst16 = 1'b0; jmp16 = 1'b1; jt16 = 16'hFFFC;
    @(negedge clk);
    check("w16_pc", {16'h0, pc16}, 32'hFFFC);
    check("w16_pc4_wrap", {16'h0, pc4_16}, 32'h0);
    jmp16 = 1'b0;
    @(negedge clk);
    check("w16_pc_wrap", {16'h0, pc16}, 32'h0);
    check("w16_pc4", {16'h0, pc4_16}, 32'h4);
    check("w16_misalign", {31'b0, mis16 | pv16}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
